latch_q_monitor: RTL and testbench
==================================

Name: latch_q_monitor

Overview:
- Clocked consumer placed directly downstream of the set/reset D latch (active-low set_n/reset_n, gate g).
- Samples the latch's asynchronous q/q_n pair into the clk domain and filters glitches on that pair.
- Tracks the latch state in an FSM, counts rising and falling edges of q, and flags the illegal q==q_n condition that occurs when set_n and reset_n are both low.
- Gives the system a clean, countable view of latch activity.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input bit (minimum 2).
- STABLE_CYC, 2, consecutive identical synchronized samples required before a pair is accepted (minimum 1).
- CNT_W, 8, width of the rise and fall event counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- q  input  1  latch output, asynchronous to clk.
- q_n  input  1  latch complementary output, asynchronous to clk.
- clear  input  1  synchronous pulse; clears counters and sticky flags.
- q_state  output  1  filtered latch value: 1 only in state HIGH.
- state  output  2  FSM state: INIT=00, LOW=01, HIGH=10, BAD=11.
- rise_pulse  output  1  one-cycle pulse on an accepted LOW->HIGH transition.
- fall_pulse  output  1  one-cycle pulse on an accepted HIGH->LOW transition.
- bad_pulse  output  1  one-cycle pulse on entry to BAD.
- invalid  output  1  sticky; set on any entry to BAD.
- rise_cnt  output  CNT_W  count of accepted rises.
- fall_cnt  output  CNT_W  count of accepted falls.
- cnt_ovf  output  1  sticky; set when either counter wraps.

Behaviour:
- Reset (sampled high at a clk edge):
  - All outputs go to 0, state goes to INIT.
  - Synchronizer flops go to 0; the filter candidate and its counter are cleared.
  - Reset has priority over all other events.
- Reset mid-operation: everything clears on that edge. After release the full acceptance latency applies again before INIT is left, and no pulse is generated for the first accepted pair.
- Synchronizer: q and q_n each pass through SYNC_STAGES flops. This yields a synchronized pair s = {q, q_n}.
- Filter:
  - A candidate pair is accepted only after s has been identical for STABLE_CYC consecutive edges.
  - A change in s restarts the stability count.
  - Latency: a pair that is stable from sampling edge E0 updates state at edge E0 + SYNC_STAGES + STABLE_CYC - 1 (E0+3 with defaults).
  - Pulses are high during the cycle immediately after that edge.
- FSM transitions on accepted pair p:
  - INIT: p=10 -> HIGH; p=01 -> LOW; p=00 or 11 -> BAD. No rise/fall pulses and no counting out of INIT. bad_pulse fires if the target is BAD.
  - LOW: p=10 -> HIGH with rise_pulse and rise_cnt+1.
  - HIGH: p=01 -> LOW with fall_pulse and fall_cnt+1.
  - LOW or HIGH with p=00 or 11 -> BAD with bad_pulse and invalid set.
  - BAD: p=10 -> HIGH or p=01 -> LOW silently (recovery is not an edge, no counting). Same-class pair stays in BAD with no repeat pulse.
  - An accepted pair equal to the current state produces no action.
- Counters:
  - Modulo 2^CNT_W; an increment from all-ones wraps to 0 and sets cnt_ovf.
  - rise_cnt and fall_cnt never change in the same cycle.
- clear:
  - Zeroes rise_cnt, fall_cnt, invalid and cnt_ovf.
  - Does not touch the FSM, synchronizer, filter or pulses.
  - An event in the same cycle as clear is counted after clearing: the counter becomes 1, and invalid becomes 1 if it is a BAD entry.
- Pulses are single-cycle and mutually exclusive.
- Input glitches shorter than STABLE_CYC synchronized samples never change state.

Test Plan:
- Reset high for 2 cycles, then q=0/q_n=1 held -> state=00 until the 3rd edge after the first sample, then state=01; rise_cnt=0, no pulses.
- From LOW, drive q=1/q_n=0 for 5 cycles, then back to 0/1 -> exactly one rise_pulse and one fall_pulse; rise_cnt=1, fall_cnt=1; q_state tracks with 3-cycle latency.
- From HIGH, drive q=q_n=1 (both set_n and reset_n low), then 1/0 -> bad_pulse once, invalid=1, state 11 then 10; rise_cnt unchanged; invalid stays 1 until clear.
- From LOW, a 1-cycle q=1 glitch (q_n unchanged, then restored) -> no state change, no pulses, counters unchanged.
- With CNT_W=2, perform 4 rises -> rise_cnt sequence 1,2,3,0 and cnt_ovf=1 on the 4th; then assert clear coincident with a 5th rise -> rise_cnt=1, cnt_ovf=0.
- Assert reset while in HIGH with rise_cnt=3 -> next cycle all outputs 0 and state=00; after release with q=1/q_n=0 held -> HIGH with no rise_pulse.

Source files
------------

// File: rtl/latch_q_monitor.sv
// latch_q_monitor
//   Clocked observer for the set/reset D latch output pair (q, q_n).
//   Brings the asynchronous pair into the clk domain, filters glitches,
//   tracks the latch state (INIT/LOW/HIGH/BAD) and counts accepted q edges.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   q, q_n     in   latch outputs, asynchronous to clk
//   clear      in   synchronous pulse, zeroes counters and sticky flags
//   q_state    out  1 only while the FSM is in HIGH
//   state      out  FSM state: INIT=00, LOW=01, HIGH=10, BAD=11
//   rise_pulse out  one-cycle pulse on accepted LOW->HIGH
//   fall_pulse out  one-cycle pulse on accepted HIGH->LOW
//   bad_pulse  out  one-cycle pulse on entry to BAD
//   invalid    out  sticky, set on any entry to BAD
//   rise_cnt   out  accepted rise count (modulo 2^CNT_W)
//   fall_cnt   out  accepted fall count (modulo 2^CNT_W)
//   cnt_ovf    out  sticky, set when either counter wraps
module latch_q_monitor #(
  parameter int SYNC_STAGES = 2,  // >= 2
  parameter int STABLE_CYC  = 2,  // >= 1
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q,
  input  logic             q_n,
  input  logic             clear,
  output logic             q_state,
  output logic [1:0]       state,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             bad_pulse,
  output logic             invalid,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             cnt_ovf
);

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  localparam int FCNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [FCNT_W-1:0] STABLE_F = FCNT_W'(STABLE_CYC);

  // ---------------------------------------------------------------------------
  // Synchronizer. A parallel valid chain marks when the stages hold real
  // samples taken after reset, so the zeros flushed in by reset are never
  // mistaken for an illegal 00 pair.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] q_sync_q;
  logic [SYNC_STAGES-1:0] qn_sync_q;
  logic [SYNC_STAGES-1:0] vld_sync_q;
  logic [1:0]             s_pair;
  logic                   s_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_sync_q   <= '0;
      qn_sync_q  <= '0;
      vld_sync_q <= '0;
    end else begin
      q_sync_q   <= {q_sync_q[SYNC_STAGES-2:0], q};
      qn_sync_q  <= {qn_sync_q[SYNC_STAGES-2:0], q_n};
      vld_sync_q <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s_pair = {q_sync_q[SYNC_STAGES-1], qn_sync_q[SYNC_STAGES-1]};
  assign s_vld  = vld_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stability filter. fcnt_q is the length of the current run of identical
  // samples (0 = no candidate yet), saturating at STABLE_CYC. A pair is
  // accepted exactly once, on the sample that brings the run to STABLE_CYC.
  // ---------------------------------------------------------------------------
  logic [1:0]        cand_q, cand_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              acc;
  logic              same;

  always_comb begin
    cand_d = cand_q;
    fcnt_d = fcnt_q;
    acc    = 1'b0;
    same   = (fcnt_q != '0) && (s_pair == cand_q);
    if (s_vld) begin
      cand_d = s_pair;
      if (!same) begin
        fcnt_d = FCNT_W'(1);
      end else if (fcnt_q != STABLE_F) begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
      acc = (fcnt_d == STABLE_F) && !(same && (fcnt_q == STABLE_F));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      fcnt_q <= '0;
    end else begin
      cand_q <= cand_d;
      fcnt_q <= fcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // State tracking FSM and event decode
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  state_e target;
  logic   rise_q, rise_d;
  logic   fall_q, fall_d;
  logic   bad_q, bad_d;

  always_comb begin
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    bad_d   = 1'b0;
    case (s_pair)
      2'b10:   target = ST_HIGH;
      2'b01:   target = ST_LOW;
      default: target = ST_BAD;
    endcase
    if (acc && (target != state_q)) begin
      state_d = target;
      // Leaving INIT or BAD is never an edge; only LOW<->HIGH counts.
      rise_d  = (state_q == ST_LOW)  && (target == ST_HIGH);
      fall_d  = (state_q == ST_HIGH) && (target == ST_LOW);
      bad_d   = (target == ST_BAD);
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky flags. clear is applied before the same-cycle event.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             invalid_q, invalid_d;
  logic             ovf_q, ovf_d;
  logic             rise_wrap, fall_wrap;

  always_comb begin
    rise_cnt_d = clear ? '0 : rise_cnt_q;
    fall_cnt_d = clear ? '0 : fall_cnt_q;
    invalid_d  = clear ? 1'b0 : invalid_q;
    ovf_d      = clear ? 1'b0 : ovf_q;
    rise_wrap  = rise_d && (rise_cnt_d == '1);
    fall_wrap  = fall_d && (fall_cnt_d == '1);
    if (rise_d) rise_cnt_d = rise_cnt_d + CNT_W'(1);
    if (fall_d) fall_cnt_d = fall_cnt_d + CNT_W'(1);
    invalid_d  = invalid_d | bad_d;
    ovf_d      = ovf_d | rise_wrap | fall_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      bad_q      <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      invalid_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      bad_q      <= bad_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      invalid_q  <= invalid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q_state    = (state_q == ST_HIGH);
  assign state      = state_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign bad_pulse  = bad_q;
  assign invalid    = invalid_q;
  assign rise_cnt   = rise_cnt_q;
  assign fall_cnt   = fall_cnt_q;
  assign cnt_ovf    = ovf_q;

endmodule

// File: tb/tb_latch_q_monitor.sv
// Testbench for latch_q_monitor: directed scenarios followed by random
// stimulus, every cycle compared against a history-based reference model.
module tb_latch_q_monitor;
  localparam int SYNC = 2;
  localparam int STAB = 2;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          reset, q, q_n, clear;
  logic          q_state, rise_pulse, fall_pulse, bad_pulse, invalid, cnt_ovf;
  logic [1:0]    state;
  logic [CW-1:0] rise_cnt, fall_cnt;

  latch_q_monitor #(.SYNC_STAGES(SYNC), .STABLE_CYC(STAB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .q(q), .q_n(q_n), .clear(clear),
    .q_state(q_state), .state(state), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .bad_pulse(bad_pulse), .invalid(invalid),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw input pairs sampled at each edge since reset release.
  // The filter sees raw[k-SYNC] at edge k; a run of identical raw samples is
  // accepted once, when it reaches length STAB.
  logic [1:0] hist[$];
  int m_state, m_rise, m_fall;
  bit m_inv, m_ovf, m_rp, m_fp, m_bp;

  task automatic model_apply(input logic [1:0] p);
    int tgt;
    tgt = (p == 2'b10) ? 2 : (p == 2'b01) ? 1 : 3;
    if (tgt != m_state) begin
      if (tgt == 3) begin
        m_bp  = 1'b1;
        m_inv = 1'b1;
      end else if (m_state == 1 && tgt == 2) begin
        m_rp = 1'b1;
        if (m_rise == (1 << CW) - 1) m_ovf = 1'b1;
        m_rise = (m_rise + 1) % (1 << CW);
      end else if (m_state == 2 && tgt == 1) begin
        m_fp = 1'b1;
        if (m_fall == (1 << CW) - 1) m_ovf = 1'b1;
        m_fall = (m_fall + 1) % (1 << CW);
      end
      m_state = tgt;
    end
  endtask

  task automatic model_edge();
    int f, r;
    bit acc;
    m_rp = 1'b0; m_fp = 1'b0; m_bp = 1'b0;
    if (reset) begin
      hist.delete();
      m_state = 0; m_rise = 0; m_fall = 0; m_inv = 1'b0; m_ovf = 1'b0;
      return;
    end
    hist.push_back({q, q_n});
    if (clear) begin
      m_rise = 0; m_fall = 0; m_inv = 1'b0; m_ovf = 1'b0;
    end
    f = hist.size() - 1 - SYNC;
    r = f - STAB + 1;
    if (r >= 0) begin
      acc = 1'b1;
      for (int i = r + 1; i <= f; i++) if (hist[i] != hist[r]) acc = 1'b0;
      if (r > 0 && hist[r-1] == hist[r]) acc = 1'b0;
      if (acc) model_apply(hist[f]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state",      state,      m_state);
    check("q_state",    q_state,    (m_state == 2));
    check("rise_pulse", rise_pulse, m_rp);
    check("fall_pulse", fall_pulse, m_fp);
    check("bad_pulse",  bad_pulse,  m_bp);
    check("invalid",    invalid,    m_inv);
    check("rise_cnt",   rise_cnt,   m_rise);
    check("fall_cnt",   fall_cnt,   m_fall);
    check("cnt_ovf",    cnt_ovf,    m_ovf);
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    {q, q_n} = p;
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; q = 1'b0; q_n = 1'b1;
    step(); step();
    reset = 1'b0;

    // Power-up: INIT for three edges, LOW on the third edge after the first sample
    for (int i = 0; i < 3; i++) begin
      step();
      check("tp_init_state", state, 2'b00);
    end
    step();
    check("tp_low_state", state, 2'b01);
    check("tp_low_rise", rise_cnt, 0);

    // One rise and one fall
    hold(2'b10, 5);
    hold(2'b01, 5);
    check("tp_rf_rise", rise_cnt, 1);
    check("tp_rf_fall", fall_cnt, 1);

    // HIGH -> BAD -> HIGH recovery
    hold(2'b10, 5);
    hold(2'b11, 5);
    check("tp_bad_state", state, 2'b11);
    check("tp_bad_inv", invalid, 1'b1);
    hold(2'b10, 5);
    check("tp_rec_state", state, 2'b10);
    check("tp_rec_rise", rise_cnt, 2);
    check("tp_rec_inv", invalid, 1'b1);

    // One-cycle glitch from LOW
    hold(2'b01, 5);
    hold(2'b10, 1);
    hold(2'b01, 5);
    check("tp_glitch_state", state, 2'b01);
    check("tp_glitch_rise", rise_cnt, 2);

    // Counter wrap, then clear coincident with a rise
    clear = 1'b1; step(); clear = 1'b0;
    check("tp_clr_inv", invalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      hold(2'b10, 5);
      check("tp_wrap_rise", rise_cnt, (i + 1) % 4);
      hold(2'b01, 5);
    end
    check("tp_wrap_ovf", cnt_ovf, 1'b1);
    {q, q_n} = 2'b10;
    step(); step(); step();
    clear = 1'b1; step(); clear = 1'b0;
    check("tp_clrev_rise", rise_cnt, 1);
    check("tp_clrev_ovf", cnt_ovf, 1'b0);
    check("tp_clrev_pulse", rise_pulse, 1'b1);
    hold(2'b10, 2);
    for (int i = 0; i < 2; i++) begin
      hold(2'b01, 5);
      hold(2'b10, 5);
    end
    check("tp_pre_rst_rise", rise_cnt, 3);

    // Reset while HIGH
    reset = 1'b1; step(); reset = 1'b0;
    check("tp_rst_state", state, 2'b00);
    check("tp_rst_rise", rise_cnt, 0);
    check("tp_rst_qstate", q_state, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("tp_rst_init", state, 2'b00);
    end
    step();
    check("tp_rst_high", state, 2'b10);
    check("tp_rst_norise", rise_pulse, 1'b0);

    // Random segments with occasional clear and reset
    repeat (400) begin
      int sel, len;
      logic [1:0] p;
      sel = $urandom_range(0, 9);
      p = (sel < 4) ? 2'b10 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b00 : 2'b11;
      len = $urandom_range(1, 6);
      {q, q_n} = p;
      repeat (len) begin
        clear = ($urandom_range(0, 15) == 0);
        reset = ($urandom_range(0, 199) == 0);
        step();
      end
      clear = 1'b0;
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
